// File: rtl/alu4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu4_pkg                                                      |
// | Purpose  : Shared opcodes, FSM state encoding and default width for the  |
// |            sequential 4-bit ALU front-end.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package alu4_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu4_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu4_addsub                                                   |
// | Purpose  : Combinational adder/subtractor shared by ADD, SUB, INC and    |
// |            the multiply accumulate step.                                 |
// | Ports    : a, b   - operands                                             |
// |            sub    - invert b before adding                               |
// |            cin    - carry in                                             |
// |            sum    - low WIDTH bits of a + b' + cin                       |
// |            carry  - bit WIDTH of the internal sum                        |
// |            ovf    - signed two's-complement overflow                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu4_addsub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];
  // Overflow only when both addends share a sign and the result flips it.
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu4_seq_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu4_seq_unit                                                 |
// | Purpose  : Sequential front-end for the 4-bit ALU. Accepts operands and  |
// |            opcode over valid/ready, runs single-cycle ops or a           |
// |            shift-add multiply, and holds registered result and flags     |
// |            until the consumer takes them.                                |
// | Ports    : clk, rst_n (async, active low)                                |
// |            in_valid/in_ready, op, a, b       - request side              |
// |            out_valid/out_ready               - response handshake        |
// |            result, result_hi, carry, zero, ovf, illegal - response data  |
// | Config   : ALU_MUL_EN defined   -> op 111 runs the multiply path         |
// |            ALU_MUL_EN undefined -> op 111 is reported as illegal         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu4_seq_unit
  import alu4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  // Counter spans: 0 = load step, 1..WIDTH = multiply iterations,
  // WIDTH+1 = final register step.
  localparam int              CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef ALU_MUL_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH + 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;

  // Shared adder connections
  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;

  // Single-cycle op results
  logic [WIDTH-1:0] exec_res;
  logic             exec_carry;
  logic             exec_ovf;
  logic             exec_ill;

`ifdef ALU_MUL_EN
  // Accumulator {acc_hi, acc_lo}; acc_lo starts as the multiplier and fills
  // with product bits as it shifts right.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          state_nxt = (op == OP_MUL) ? MUL : EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      // First EXEC cycle is the load step, second registers the result.
      EXEC: if (cnt != '0) state_nxt = DONE;
`ifdef ALU_MUL_EN
      MUL:  if (cnt == MUL_LAST) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------- adder mux
  always_comb begin
    as_a   = a_q;
    as_b   = b_q;
    as_sub = 1'b0;
    as_cin = 1'b0;
    case (op_q)
      OP_SUB: begin
        as_sub = 1'b1;
        as_cin = 1'b1;
      end
      OP_INC: begin
        as_b   = '0;
        as_cin = 1'b1;
      end
      default: ;
    endcase
`ifdef ALU_MUL_EN
    // Multiply step: acc_hi += multiplicand when the multiplier LSB is set.
    if (state == MUL) begin
      as_a   = acc_hi;
      as_b   = acc_lo[0] ? a_q : '0;
      as_sub = 1'b0;
      as_cin = 1'b0;
    end
`endif
  end

  alu4_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a     (as_a),
    .b     (as_b),
    .sub   (as_sub),
    .cin   (as_cin),
    .sum   (as_sum),
    .carry (as_carry),
    .ovf   (as_ovf)
  );

  // ------------------------------------------------- single-cycle result
  always_comb begin
    exec_res   = '0;
    exec_carry = 1'b0;
    exec_ovf   = 1'b0;
    exec_ill   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC: begin
        exec_res   = as_sum;
        exec_carry = as_carry;
        exec_ovf   = as_ovf;
      end
      OP_NOT: exec_res = ~a_q;
      OP_AND: exec_res = a_q & b_q;
      OP_OR:  exec_res = a_q | b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      default: begin
`ifndef ALU_MUL_EN
        // Multiply not built: report it and return an all-zero result.
        exec_ill = 1'b1;
`endif
      end
    endcase
  end

  // ------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_hi    <= '0;
      acc_lo    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= '0;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            cnt <= CNT_ONE;
          end else begin
            result    <= exec_res;
            result_hi <= '0;
            carry     <= exec_carry;
            ovf       <= exec_ovf;
            zero      <= (exec_res == '0);
            illegal   <= exec_ill;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (cnt == '0) begin
            acc_hi <= '0;
            acc_lo <= b_q;
            cnt    <= CNT_ONE;
          end else if (cnt != MUL_LAST) begin
            // Shift {carry, sum, acc_lo} right by one.
            acc_hi <= {as_carry, as_sum[WIDTH-1:1]};
            acc_lo <= {as_sum[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + CNT_ONE;
          end else begin
            result    <= acc_lo;
            result_hi <= acc_hi;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= ({acc_hi, acc_lo} == '0);
            illegal   <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu4_seq_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu4_seq_unit                                              |
// | Purpose  : Self-checking bench for alu4_seq_unit (WIDTH=4) with directed |
// |            cases and random transactions against an arithmetic model.   |
// |            Honors ALU_MUL_EN the same way the design does.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu4_seq_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] result_hi;
  logic       carry;
  logic       zero;
  logic       ovf;
  logic       illegal;

  int tests = 0;
  int fails = 0;

  alu4_seq_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference model straight from the opcode definitions.
  task automatic model(input int o, input int x, input int y,
                       output int r, output int hi, output int c, output int z,
                       output int v, output int ill, output int lat);
    int s;
    r = 0; hi = 0; c = 0; v = 0; ill = 0; lat = 2;
    case (o)
      0: begin s = x + y; r = s % 16; c = s / 16;
               s = sgn4(x) + sgn4(y); v = (s > 7 || s < -8) ? 1 : 0; end
      1: begin r = (x - y + 16) % 16; c = (x >= y) ? 1 : 0;
               s = sgn4(x) - sgn4(y); v = (s > 7 || s < -8) ? 1 : 0; end
      2: r = 15 - x;
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: begin s = x + 1; r = s % 16; c = s / 16; v = (x == 7) ? 1 : 0; end
      default: begin
`ifdef ALU_MUL_EN
        s = x * y; r = s % 16; hi = s / 16; lat = 6;
`else
        ill = 1;
`endif
      end
    endcase
    z = (r == 0 && hi == 0) ? 1 : 0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  // One full transaction: accept, wait for result, optional backpressure,
  // then handshake. Inputs are scrambled right after accept.
  task automatic txn(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                     input int hold);
    int er, ehi, ec, ez, ev, eill, elat, lat;
    model(int'(o), int'(x), int'(y), er, ehi, ec, ez, ev, eill, elat);
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = 4'($urandom);
    b  = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("latency op%0d", o), lat, elat);
    check($sformatf("result op%0d %0h,%0h", o, x, y), result, er);
    check($sformatf("result_hi op%0d", o), result_hi, ehi);
    check($sformatf("flags op%0d {c,z,v,ill}", o), {carry, zero, ovf, illegal},
          {ec[0], ez[0], ev[0], eill[0]});
    for (int i = 0; i < hold; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      @(posedge clk);
      #1;
      check("held result", {out_valid, in_ready, result, result_hi}, {1'b1, 1'b0, er[3:0], ehi[3:0]});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after handshake {out_valid,in_ready}", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", {in_ready, out_valid, result, result_hi, carry, zero, ovf, illegal},
          {1'b1, 1'b0, 4'h0, 4'h0, 4'b0000});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    txn(3'b000, 4'h7, 4'h9, 0);   // ADD wraps to 0 with carry
    txn(3'b001, 4'h3, 4'h5, 0);   // SUB borrow
    txn(3'b000, 4'h7, 4'h1, 0);   // ADD signed overflow
    txn(3'b110, 4'hF, 4'h0, 0);   // INC wrap
    txn(3'b111, 4'hF, 4'hF, 0);   // MUL max
    txn(3'b101, 4'hA, 4'h5, 3);   // XOR with backpressure
    txn(3'b010, 4'h0, 4'h3, 1);   // NOT

    // Reset in the middle of a long operation
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    op        = 3'b111;
    a         = 4'hF;
    b         = 4'hF;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset", {in_ready, out_valid, result, result_hi, carry, zero, ovf, illegal},
          {1'b1, 1'b0, 4'h0, 4'h0, 4'b0000});
    @(negedge clk);
    rst_n = 1'b1;
    txn(3'b000, 4'h1, 4'h1, 0);

    // Back-to-back with in_valid held high
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    op        = 3'b011;
    a         = 4'hC;
    b         = 4'hA;
    out_ready = 1'b1;
    @(posedge clk);               // first accept
    #1;
    op = 3'b100;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("b2b first", {out_valid, result}, {1'b1, 4'h8});
    @(posedge clk);               // handshake
    #1;
    check("b2b ready after handshake", {out_valid, in_ready}, 2'b01);
    @(posedge clk);               // second accept
    #1;
    check("b2b second accepted", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("b2b second", {out_valid, result}, {1'b1, 4'hE});
    @(posedge clk);
    #1;

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      txn(3'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
